frac_lut: RTL
=============

# frac_lut

Configurable, fracturable look-up table with a streaming configuration port. It extends the plain 2^K:1 LUT select with double-buffered configuration load, a fractured mode (two (K-1)-input LUTs sharing lower inputs), and per-output optional registering. It is the basic logic cell instantiated by the LUT-array tile; configuration beats come from the tile's config chain controller.

## Interface
- INPUTS, 4, LUT inputs K (≥2)
- WIDTH, 1<<INPUTS, truth-table bits; must equal 2^INPUTS
- CFG_WIDTH, 1, config bits per beat (1..WIDTH+3)
- PREDECODE, 1, 1 = two MSB selects resolved by final 4:1 stage; 0 = flat WIDTH:1 mux (function identical)
- clk  in  1  clock; all flops rising-edge
- rst_n  in  1  reset; asynchronous, active-low
- cfg_valid  in  1  config beat valid
- cfg_ready  out  1  config beat accepted when valid & ready
- cfg_data  in  CFG_WIDTH  config beat
- cfg_abort  in  1  discard in-progress load
- cfg_done  out  1  one-cycle pulse on commit
- configured  out  1  active config valid
- ce  in  1  clock enable for output registers
- s  in  INPUTS  LUT select
- za  out  1  output A
- zb  out  1  output B

## Operation
- Config image CFG_BITS = WIDTH+3: bits [WIDTH-1:0] truth table, [WIDTH] FRAC, [WIDTH+1] REG_A, [WIDTH+2] REG_B.
- BEATS = ceil(CFG_BITS/CFG_WIDTH); beat k carries image bits [k*CFG_WIDTH +: CFG_WIDTH]; bits beyond CFG_BITS in final beat ignored.
- Double buffered: beats fill a shadow register; active register updated only at commit. LUT always evaluates active config.
- FSM: IDLE, LOAD. cfg_ready = 1 in both states.
  - IDLE: accepted beat → LOAD, beat_cnt=1 (if BEATS=1, commit immediately, stay IDLE).
  - LOAD: each accepted beat increments beat_cnt; beat BEATS-1 → commit, beat_cnt=0, IDLE.
  - LOAD & cfg_abort → IDLE, beat_cnt=0, active untouched; abort wins over a simultaneous beat (beat dropped). cfg_abort in IDLE ignored.
- Commit: active ← shadow, configured ← 1, cfg_done pulses same edge (high following cycle only).
- Function (t = active table, lo = s[INPUTS-2:0]):
  - FRAC=0: fa = t[s], fb = 0.
  - FRAC=1: fa = t[lo] (lower half), fb = t[WIDTH/2 + lo] (upper half); s[INPUTS-1] ignored.
  - configured=0: fa = fb = 0.
- Outputs: za = REG_A ? qa : fa; zb = REG_B ? qb : fb. qa/qb load fa/fb on clk when ce=1, hold when ce=0.

## Timing
- Reset: state IDLE, beat_cnt 0, shadow 0, active 0, configured 0, cfg_done 0, qa=qb=0; za=zb=0; cfg_ready 1 once rst_n high.
- Unregistered path: s → za/zb combinational, zero latency.
- Registered path: one cycle, gated by ce.
- Commit edge: combinational outputs switch to new function right after edge; qa/qb capture at commit edge using old config; first new-config capture on next edge.
- Reload from configured state: old function stays live until commit; no glitch in configured.
- Reset mid-load: shadow and active cleared; configuration lost.
- Throughput: one beat per cycle; full load = BEATS cycles; back-to-back loads with no bubble.

## Structure
- Package frac_lut_pkg: state enum (IDLE, LOAD), mode bit offsets (FRAC/REG_A/REG_B relative to WIDTH), function cfg_beats(width, cfg_width).
- Sub-module lut_mux (params INPUTS, PREDECODE): pure combinational table select; instantiated twice at INPUTS-1 for fractured halves, full K result built as 2:1 of the halves on s[INPUTS-1].
- Top holds FSM, beat counter, shadow/active registers, output flops.

## Test plan
- Reset then s sweep with no config → za=zb=0 throughout, configured=0, cfg_ready=1.
- INPUTS=4, CFG_WIDTH=1: load 19 beats, table 16'hCAFE, FRAC=0, REG_A=0 → cfg_done one pulse after beat 19; za = bit s of 16'hCAFE for all s, zb=0.
- Fractured: table 16'hA5_3C, FRAC=1 → s=3'b010: za=t[2]=1, zb=t[10]=1; s[3] toggled, outputs unchanged.
- REG_A=1, ce held low 3 cycles then high → za holds, then updates one cycle after ce rises.
- Reload 16'h0000 over active 16'hFFFF, cfg_abort on beat 10 → za stays 1 for all s, configured stays 1, no cfg_done.
- CFG_WIDTH=8 (3 beats, final beat upper 5 bits ignored), rst_n asserted mid-load → all state cleared, subsequent full load succeeds.

Source files
------------

// File: rtl/frac_lut_pkg.sv
// -----------------------------------------------------------------------------
// frac_lut_pkg
// Shared definitions for the fracturable LUT cell:
//   - load FSM state encoding
//   - offsets of the mode bits that follow the truth table in the config image
//   - cfg_beats(): number of config beats needed for a given table width
// -----------------------------------------------------------------------------
package frac_lut_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  // Mode bits sit directly above the truth table: image[WIDTH + *_OFS].
  localparam int FRAC_OFS  = 0;
  localparam int REGA_OFS  = 1;
  localparam int REGB_OFS  = 2;
  localparam int MODE_BITS = 3;

  // Beats needed to carry the full image (truth table + mode bits).
  function automatic int cfg_beats(input int width, input int cfg_width);
    return (width + MODE_BITS + cfg_width - 1) / cfg_width;
  endfunction

endpackage

// File: rtl/frac_lut_mux.sv
// -----------------------------------------------------------------------------
// lut_mux
// Pure combinational truth-table select: o_z = i_table[i_sel].
// With PREDECODE=1 (and at least 3 select bits) the two MSB selects are
// resolved by a final 4:1 stage over four quarter-table selects; otherwise a
// flat 2^INPUTS:1 mux is used. Both forms are functionally identical.
// Ports:
//   i_table  in  2^INPUTS  truth table
//   i_sel    in  INPUTS    select
//   o_z      out 1         selected bit
// -----------------------------------------------------------------------------
module lut_mux #(
  parameter int INPUTS    = 3,
  parameter int PREDECODE = 1
) (
  input  logic [(1<<INPUTS)-1:0] i_table,
  input  logic [INPUTS-1:0]      i_sel,
  output logic                   o_z
);

  if ((PREDECODE != 0) && (INPUTS >= 3)) begin : g_predec
    localparam int QUART = 1 << (INPUTS - 2);
    logic [3:0] w_quad;

    for (genvar g = 0; g < 4; g++) begin : g_quad
      logic [QUART-1:0] w_grp;
      assign w_grp     = i_table[g*QUART +: QUART];
      assign w_quad[g] = w_grp[i_sel[INPUTS-3:0]];
    end

    // Final 4:1 stage on the two MSB selects.
    always_comb begin
      case (i_sel[INPUTS-1:INPUTS-2])
        2'b00:   o_z = w_quad[0];
        2'b01:   o_z = w_quad[1];
        2'b10:   o_z = w_quad[2];
        2'b11:   o_z = w_quad[3];
        default: o_z = 1'b0;
      endcase
    end
  end else begin : g_flat
    assign o_z = i_table[i_sel];
  end

endmodule

// File: rtl/frac_lut.sv
// -----------------------------------------------------------------------------
// frac_lut
// Fracturable K-input LUT with a streaming, double-buffered configuration port.
// Config image (WIDTH+3 bits): [WIDTH-1:0] truth table, [WIDTH] FRAC,
// [WIDTH+1] REG_A, [WIDTH+2] REG_B. Beats fill a shadow register; the active
// register (which the LUT always evaluates) is replaced only on commit.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   cfg_valid/ready    config beat handshake (ready always high)
//   cfg_data           config beat, CFG_WIDTH bits
//   cfg_abort          drop an in-progress load (ignored when idle)
//   cfg_done           one-cycle pulse after commit
//   configured         active config valid
//   ce                 clock enable for output registers
//   s                  LUT select
//   za, zb             outputs A and B (combinational or registered per mode)
// -----------------------------------------------------------------------------
module frac_lut
  import frac_lut_pkg::*;
#(
  parameter int INPUTS    = 4,
  parameter int WIDTH     = 1 << INPUTS,
  parameter int CFG_WIDTH = 1,
  parameter int PREDECODE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CFG_WIDTH-1:0] cfg_data,
  input  logic                 cfg_abort,
  output logic                 cfg_done,
  output logic                 configured,
  input  logic                 ce,
  input  logic [INPUTS-1:0]    s,
  output logic                 za,
  output logic                 zb
);

  localparam int CFG_BITS = WIDTH + MODE_BITS;
  localparam int BEATS    = cfg_beats(WIDTH, CFG_WIDTH);
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int HALF     = WIDTH / 2;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [CNT_W-1:0]     r_beat_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_commit;
  logic                 w_beat_fire;
  logic [CFG_BITS-1:0]  r_shadow;
  logic [CFG_BITS-1:0]  w_shadow_nxt;
  logic [CFG_BITS-1:0]  r_active;
  logic                 r_configured;
  logic                 r_cfg_done;
  logic                 r_qa;
  logic                 r_qb;
  logic                 w_lo_z;
  logic                 w_hi_z;
  logic                 w_full_z;
  logic                 w_frac;
  logic                 w_reg_a;
  logic                 w_reg_b;
  logic                 w_fa;
  logic                 w_fb;

  assign cfg_ready = 1'b1;

  // Load FSM: beat acceptance, beat counting, abort and commit decision.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_beat_cnt;
    w_commit    = 1'b0;
    w_beat_fire = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_valid) begin
          w_beat_fire = 1'b1;
          if (BEATS == 1) begin
            w_commit  = 1'b1;
            w_cnt_nxt = {CNT_W{1'b0}};
          end else begin
            w_state_nxt = ST_LOAD;
            w_cnt_nxt   = CNT_W'(1);
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Abort wins over a beat presented in the same cycle.
        if (cfg_abort) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else if (cfg_valid) begin
          w_beat_fire = 1'b1;
          if (r_beat_cnt == LAST_BEAT) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = {CNT_W{1'b0}};
          end else begin
            w_cnt_nxt = r_beat_cnt + CNT_W'(1);
          end
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Shadow next value: image bit p comes from beat p/CFG_WIDTH, lane
  // p%CFG_WIDTH. Beat lanes beyond the image are never stored.
  for (genvar p = 0; p < CFG_BITS; p++) begin : g_shadow_bit
    localparam int BEAT_IDX = p / CFG_WIDTH;
    localparam int LANE     = p % CFG_WIDTH;
    assign w_shadow_nxt[p] = (w_beat_fire && (r_beat_cnt == CNT_W'(BEAT_IDX)))
                             ? cfg_data[LANE] : r_shadow[p];
  end

  // Config state: FSM, counter, shadow/active images, configured and done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_beat_cnt   <= {CNT_W{1'b0}};
      r_shadow     <= {CFG_BITS{1'b0}};
      r_active     <= {CFG_BITS{1'b0}};
      r_configured <= 1'b0;
      r_cfg_done   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_cnt_nxt;
      r_shadow   <= w_shadow_nxt;
      r_cfg_done <= w_commit;
      if (w_commit) begin
        // Take the final beat directly so commit needs no extra cycle.
        r_active     <= w_shadow_nxt;
        r_configured <= 1'b1;
      end else begin
        r_active     <= r_active;
        r_configured <= r_configured;
      end
    end
  end

  assign w_frac  = r_active[WIDTH + FRAC_OFS];
  assign w_reg_a = r_active[WIDTH + REGA_OFS];
  assign w_reg_b = r_active[WIDTH + REGB_OFS];

  lut_mux #(
    .INPUTS    (INPUTS - 1),
    .PREDECODE (PREDECODE)
  ) u_mux_lo (
    .i_table (r_active[HALF-1:0]),
    .i_sel   (s[INPUTS-2:0]),
    .o_z     (w_lo_z)
  );

  lut_mux #(
    .INPUTS    (INPUTS - 1),
    .PREDECODE (PREDECODE)
  ) u_mux_hi (
    .i_table (r_active[WIDTH-1:HALF]),
    .i_sel   (s[INPUTS-2:0]),
    .o_z     (w_hi_z)
  );

  // Full K-input result is the 2:1 of the two halves on the top select.
  assign w_full_z = s[INPUTS-1] ? w_hi_z : w_lo_z;

  // Output functions; forced low until a configuration has been committed.
  always_comb begin
    w_fa = 1'b0;
    w_fb = 1'b0;
    if (!r_configured) begin
      w_fa = 1'b0;
      w_fb = 1'b0;
    end else if (w_frac) begin
      w_fa = w_lo_z;
      w_fb = w_hi_z;
    end else begin
      w_fa = w_full_z;
      w_fb = 1'b0;
    end
  end

  // Optional output registers, loaded only when ce is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qa <= 1'b0;
      r_qb <= 1'b0;
    end else if (ce) begin
      r_qa <= w_fa;
      r_qb <= w_fb;
    end else begin
      r_qa <= r_qa;
      r_qb <= r_qb;
    end
  end

  assign za         = w_reg_a ? r_qa : w_fa;
  assign zb         = w_reg_b ? r_qb : w_fb;
  assign cfg_done   = r_cfg_done;
  assign configured = r_configured;

endmodule
